// File: rtl/cmd_exec.sv
// Command executor: pops one command word, performs a single memory read or write,
// and streams an ASCII-framed response into the TX response FIFO.
module cmd_exec #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 8 + ADDR_W + DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_fifo_empty,
  output logic              cmd_fifo_rd_en,
  input  logic [CMD_W-1:0]  cmd_fifo_rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              rsp_fifo_full,
  output logic              rsp_fifo_wr_en,
  output logic [7:0]        rsp_fifo_wr_data,
  output logic              busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 2);
  localparam int TO_W   = $clog2(TIMEOUT);
  localparam int SR_W   = 8 + DATA_W;

  localparam logic [7:0] OP_RD  = 8'h52;
  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] RSP_K  = 8'h4B;
  localparam logic [7:0] RSP_D  = 8'h44;
  localparam logic [7:0] RSP_E  = 8'h45;
  localparam logic [7:0] RSP_T  = 8'h54;

  // state | meaning: IDLE wait for cmd, POP fifo latency, DECODE check opcode, MEM bus access, RSP stream bytes
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    RSP    = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [7:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              op_legal;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic [SR_W-1:0]   rsp_sr;
  logic [CNT_W-1:0]  rsp_cnt;
  logic              push;
  logic              last_push;

  assign cmd_op    = cmd_fifo_rd_data[CMD_W-1 -: 8];
  assign cmd_addr  = cmd_fifo_rd_data[DATA_W +: ADDR_W];
  assign cmd_wdata = cmd_fifo_rd_data[DATA_W-1:0];
  assign op_legal  = (cmd_op == OP_RD) || (cmd_op == OP_WR);
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT - 1));

  assign push      = (state == RSP) && !rsp_fifo_full;
  assign last_push = push && (rsp_cnt == CNT_W'(1));

  assign rsp_fifo_wr_en   = push;
  assign rsp_fifo_wr_data = rsp_sr[SR_W-1 -: 8];
  assign busy             = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!cmd_fifo_empty) state_nx = POP;
      POP:     state_nx = DECODE;
      DECODE:  state_nx = op_legal ? MEM : RSP;
      MEM:     if (mem_ack || to_hit) state_nx = RSP;
      RSP:     if (last_push) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_fifo_rd_en <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      to_cnt         <= '0;
      rsp_sr         <= '0;
      rsp_cnt        <= '0;
    end else begin
      cmd_fifo_rd_en <= (state == IDLE) && !cmd_fifo_empty;
      case (state)
        DECODE: begin
          if (op_legal) begin
            mem_req   <= 1'b1;
            mem_we    <= (cmd_op == OP_WR);
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;
            to_cnt    <= '0;
          end else begin
            rsp_sr  <= {RSP_E, {DATA_W{1'b0}}};
            rsp_cnt <= CNT_W'(1);
          end
        end
        MEM: begin
          // ack takes priority over a simultaneous timeout terminal count
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              rsp_sr  <= {RSP_K, {DATA_W{1'b0}}};
              rsp_cnt <= CNT_W'(1);
            end else begin
              rsp_sr  <= {RSP_D, mem_rdata};
              rsp_cnt <= CNT_W'(NBYTES + 1);
            end
          end else if (to_hit) begin
            mem_req <= 1'b0;
            rsp_sr  <= {RSP_T, {DATA_W{1'b0}}};
            rsp_cnt <= CNT_W'(1);
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RSP: begin
          if (push) begin
            rsp_sr  <= rsp_sr << 8;
            rsp_cnt <= rsp_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_exec.sv
// Directed bench for cmd_exec: FIFO and memory models around the DUT, immediate
// assertions against hand-computed responses and bus behaviour.
module tb_cmd_exec;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int CMD_W   = 8 + ADDR_W + DATA_W;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_fifo_empty;
  logic              cmd_fifo_rd_en;
  logic [CMD_W-1:0]  cmd_fifo_rd_data = '0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              rsp_fifo_full = 1'b0;
  logic              rsp_fifo_wr_en;
  logic [7:0]        rsp_fifo_wr_data;
  logic              busy;

  always #5 clk = ~clk;

  cmd_exec #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_rd_en(cmd_fifo_rd_en),
    .cmd_fifo_rd_data(cmd_fifo_rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_fifo_full(rsp_fifo_full), .rsp_fifo_wr_en(rsp_fifo_wr_en),
    .rsp_fifo_wr_data(rsp_fifo_wr_data), .busy(busy)
  );

  // command FIFO model: head data appears the cycle after the pop strobe
  logic [CMD_W-1:0] cmd_mem [0:31];
  int cmd_wp = 0;
  int cmd_rp = 0;
  assign cmd_fifo_empty = (cmd_wp == cmd_rp);

  always @(posedge clk) begin
    if (cmd_fifo_rd_en && (cmd_rp != cmd_wp)) begin
      cmd_fifo_rd_data <= cmd_mem[cmd_rp % 32];
      cmd_rp <= cmd_rp + 1;
    end
  end

  // monitors
  logic [7:0] rsp_mem [0:63];
  int rsp_n = 0, req_cyc = 0, rd_pulses = 0, rd_double = 0, full_push = 0, stab_err = 0;
  logic prev_req = 1'b0, prev_rd = 1'b0;
  logic [ADDR_W+DATA_W:0] prev_bus = '0;

  always @(posedge clk) begin
    if (rsp_fifo_wr_en) begin
      rsp_mem[rsp_n % 64] <= rsp_fifo_wr_data;
      rsp_n <= rsp_n + 1;
      if (rsp_fifo_full) full_push <= full_push + 1;
    end
    if (mem_req) req_cyc <= req_cyc + 1;
    if (cmd_fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (cmd_fifo_rd_en && prev_rd) rd_double <= rd_double + 1;
    if (mem_req && prev_req && ({mem_we, mem_addr, mem_wdata} != prev_bus))
      stab_err <= stab_err + 1;
    prev_req <= mem_req;
    prev_rd  <= cmd_fifo_rd_en;
    prev_bus <= {mem_we, mem_addr, mem_wdata};
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
    chk($sformatf("%s byte%0d", tag, idx), {56'd0, rsp_mem[idx % 64]}, {56'd0, exp});
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
    cmd_mem[cmd_wp % 32] = {op, a, d};
    cmd_wp = cmd_wp + 1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req seen"}, {63'd0, mem_req}, 64'd1);
  endtask

  task automatic pulse_ack(input int dly, input logic [31:0] d);
    repeat (dly) @(negedge clk);
    mem_rdata = d;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic wait_rsp(input string tag, input int target);
    int n = 0;
    while ((rsp_n < target || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, {63'd0, (rsp_n >= target) && !busy}, 64'd1);
  endtask

  int base, rq, fp, rp;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst mem_req",  {63'd0, mem_req}, 64'd0);
    chk("rst rd_en",    {63'd0, cmd_fifo_rd_en}, 64'd0);
    chk("rst busy",     {63'd0, busy}, 64'd0);
    chk("rst wr_en",    {63'd0, rsp_fifo_wr_en}, 64'd0);
    chk("rst outs",     {15'd0, mem_we, mem_addr, mem_wdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // write, ack 3 cycles after req
    base = rsp_n; rq = req_cyc;
    push_cmd(8'h57, 16'h0010, 32'hDEADBEEF);
    wait_req("wr");
    chk("wr we",    {63'd0, mem_we}, 64'd1);
    chk("wr addr",  {48'd0, mem_addr}, 64'h10);
    chk("wr wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    pulse_ack(3, 32'h0);
    chk("wr req drop", {63'd0, mem_req}, 64'd0);
    wait_rsp("wr", base + 1);
    chk("wr count", rsp_n - base, 64'd1);
    chk_byte("wr", base, 8'h4B);
    chk("wr req cycles", req_cyc - rq, 64'd4);

    // read
    base = rsp_n;
    push_cmd(8'h52, 16'h0020, 32'hFFFF0000);
    wait_req("rd");
    chk("rd we",   {63'd0, mem_we}, 64'd0);
    chk("rd addr", {48'd0, mem_addr}, 64'h20);
    pulse_ack(0, 32'h12345678);
    wait_rsp("rd", base + 5);
    chk("rd count", rsp_n - base, 64'd5);
    chk_byte("rd", base,     8'h44);
    chk_byte("rd", base + 1, 8'h12);
    chk_byte("rd", base + 2, 8'h34);
    chk_byte("rd", base + 3, 8'h56);
    chk_byte("rd", base + 4, 8'h78);

    // illegal opcode followed by a queued write
    base = rsp_n; rq = req_cyc;
    push_cmd(8'h41, 16'h0000, 32'h0);
    push_cmd(8'h57, 16'h0050, 32'h01020304);
    for (int n = 0; n < 60 && rsp_n < base + 1; n++) @(negedge clk);
    chk("ill rsp", rsp_n - base, 64'd1);
    chk_byte("ill", base, 8'h45);
    chk("ill no req", req_cyc - rq, 64'd0);
    wait_req("ill next");
    chk("ill next addr", {48'd0, mem_addr}, 64'h50);
    pulse_ack(1, 32'h0);
    wait_rsp("ill next", base + 2);
    chk_byte("ill next", base + 1, 8'h4B);

    // timeout, then a stray late ack
    base = rsp_n; rq = req_cyc;
    push_cmd(8'h52, 16'h0077, 32'h0);
    wait_rsp("to", base + 1);
    chk_byte("to", base, 8'h54);
    chk("to req cycles", req_cyc - rq, 64'd8);
    pulse_ack(0, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    chk("late ack rsp",  rsp_n - base, 64'd1);
    chk("late ack busy", {63'd0, busy}, 64'd0);
    chk("late ack req",  req_cyc - rq, 64'd8);

    // read with the response FIFO toggling full
    base = rsp_n; fp = full_push;
    push_cmd(8'h52, 16'h0100, 32'h0);
    wait_req("full");
    rsp_fifo_full = 1'b1;
    pulse_ack(0, 32'hA5C30F96);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rsp_fifo_full = ~rsp_fifo_full;
    end
    rsp_fifo_full = 1'b0;
    wait_rsp("full", base + 5);
    chk("full count", rsp_n - base, 64'd5);
    chk("full push while full", full_push - fp, 64'd0);
    chk_byte("full", base,     8'h44);
    chk_byte("full", base + 1, 8'hA5);
    chk_byte("full", base + 2, 8'hC3);
    chk_byte("full", base + 3, 8'h0F);
    chk_byte("full", base + 4, 8'h96);

    // reset during MEM, then three queued commands
    base = rsp_n;
    push_cmd(8'h57, 16'h0030, 32'h11);
    wait_req("rst");
    rst = 1'b1;
    #1;
    chk("arst mem_req", {63'd0, mem_req}, 64'd0);
    chk("arst busy",    {63'd0, busy}, 64'd0);
    chk("arst wr_en",   {63'd0, rsp_fifo_wr_en}, 64'd0);
    chk("arst outs",    {7'd0, mem_we, cmd_fifo_rd_en, rsp_fifo_wr_data, mem_addr, mem_wdata}, 64'd0);
    push_cmd(8'h57, 16'h0031, 32'h22);
    push_cmd(8'h52, 16'h0040, 32'h0);
    push_cmd(8'h99, 16'h0041, 32'h0);
    rp = rd_pulses;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_req("q1");
    chk("q1 addr", {47'd0, mem_we, mem_addr}, 64'h1_0031);
    pulse_ack(0, 32'h0);
    wait_req("q2");
    chk("q2 addr", {47'd0, mem_we, mem_addr}, 64'h0_0040);
    pulse_ack(2, 32'hCAFEF00D);
    wait_rsp("q", base + 7);
    repeat (3) @(negedge clk);
    chk("q count", rsp_n - base, 64'd7);
    chk_byte("q", base,     8'h4B);
    chk_byte("q", base + 1, 8'h44);
    chk_byte("q", base + 2, 8'hCA);
    chk_byte("q", base + 3, 8'hFE);
    chk_byte("q", base + 4, 8'hF0);
    chk_byte("q", base + 5, 8'h0D);
    chk_byte("q", base + 6, 8'h45);
    chk("q pops", rd_pulses - rp, 64'd3);
    chk("rd_en one cycle", rd_double, 64'd0);
    chk("bus stable", stab_err, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
